// File: rtl/clfsr_pkg.sv
// clfsr_pkg: shared FSM type, default constants and Q-format helpers for the keystream generator
package clfsr_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  localparam logic [15:0] DEF_TAP_MASK = 16'hB400;
  localparam logic [15:0] DEF_X_SEED = 16'h7EF0;
  function automatic int one_q(input int xw);
    return (1 << (xw - 1)) - 1;
  endfunction
  function automatic int q_shift(input int xw);
    return xw - 2;
  endfunction
endpackage

// File: rtl/chaotic_map.sv
// chaotic_map: fixed-point x' = 1 - 2x^2 with saturation and a fixed-point (degenerate orbit) flag
module chaotic_map
  import clfsr_pkg::*;
#(
  parameter int X_W = 16
) (
  input  logic signed [X_W-1:0] x,
  output logic signed [X_W-1:0] x_next,
  output logic                  degen
);
  localparam int SH = q_shift(X_W);
  localparam logic signed [X_W:0] ONE = (X_W+1)'(one_q(X_W));
  logic signed [2*X_W-1:0] p;
  logic [2*X_W-1:0] sh;
  logic [X_W-1:0] t;
  logic signed [X_W:0] d;
  // square, rescale to 2x^2, saturate, subtract from one and clamp back to X_W bits
  always_comb begin
    p = x * x;
    sh = $unsigned(p >>> SH);
    t = |sh[2*X_W-1:X_W] ? '1 : sh[X_W-1:0];
    d = ONE - $signed({1'b0, t});
    x_next = d[X_W] == d[X_W-1] ? d[X_W-1:0] : {d[X_W], {(X_W-1){~d[X_W]}}};
    degen = x_next == x;
  end
endmodule

// File: rtl/clfsr_keystream.sv
// clfsr_keystream: multi-channel chaotic-LFSR keystream generator with seeding and valid/ready output
module clfsr_keystream
  import clfsr_pkg::*;
#(
  parameter int                NUM_CH   = 3,
  parameter int                LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] TAP_MASK = DEF_TAP_MASK,
  parameter int                WORD_W   = 8,
  parameter int                X_W      = 16,
  parameter logic [X_W-1:0]    X_SEED   = DEF_X_SEED,
  parameter int                CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       seed_valid,
  output logic                       seed_ready,
  input  logic [NUM_CH*LFSR_W-1:0]   seed_lfsr,
  input  logic [X_W-1:0]             seed_x,
  output logic                       key_valid,
  input  logic                       key_ready,
  output logic [NUM_CH*WORD_W-1:0]   key_data,
  output logic [CNT_W-1:0]           word_count,
  output logic                       x_reinit
);
  localparam int BW = $clog2(WORD_W);
  state_t state, state_d;
  logic signed [X_W-1:0] x, x_next;
  logic degen, load, step, last;
  logic [BW-1:0] bit_cnt;
  logic [NUM_CH*WORD_W-1:0] word;
  chaotic_map #(.X_W(X_W)) u_map (
    .x      (x),
    .x_next (x_next),
    .degen  (degen)
  );
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [LFSR_W-1:0] lfsr, seed;
    logic [WORD_W-1:0] shreg;
    logic b;
    assign seed = seed_lfsr[c*LFSR_W +: LFSR_W];
    assign b = lfsr[LFSR_W-1] ^ x[X_W-1];
    assign word[c*WORD_W +: WORD_W] = {shreg[WORD_W-2:0], b};
    // per-channel LFSR (zero seeds replaced to avoid lockup) and MSB-first bit packer
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        lfsr <= LFSR_W'(c + 1);
        shreg <= '0;
      end else if (load) begin
        lfsr <= seed == '0 ? LFSR_W'(c + 1) : seed;
      end else if (step) begin
        lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAP_MASK)};
        shreg <= word[c*WORD_W +: WORD_W];
      end
  end
  // control decode and next-state selection
  always_comb begin
    seed_ready = state == IDLE;
    load = seed_ready && seed_valid;
    step = state == RUN;
    last = step && bit_cnt == BW'(WORD_W - 1);
    state_d = state;
    if (seed_ready && enable) state_d = RUN;
    if (last) state_d = HOLD;
    if (state == HOLD && key_ready) state_d = enable ? RUN : IDLE;
  end
  // chaotic state, bit counter, output word register and handshake bookkeeping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      x <= X_SEED;
      bit_cnt <= '0;
      key_data <= '0;
      key_valid <= 1'b0;
      word_count <= '0;
      x_reinit <= 1'b0;
    end else begin
      state <= state_d;
      x_reinit <= step && degen;
      if (load) begin
        x <= seed_x;
        bit_cnt <= '0;
      end else if (step) begin
        x <= degen ? X_SEED : x_next;
        bit_cnt <= last ? '0 : bit_cnt + BW'(1);
      end
      if (last) begin
        key_data <= word;
        key_valid <= 1'b1;
      end else if (state == HOLD && key_ready) begin
        key_valid <= 1'b0;
        word_count <= word_count + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_clfsr_keystream.sv
// tb_clfsr_keystream: scoreboard bench for the chaotic-LFSR keystream generator
module tb_clfsr_keystream;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, seed_valid = 1'b0, key_ready = 1'b0;
  logic seed_ready, key_valid, x_reinit;
  logic [47:0] seed_lfsr = '0;
  logic [15:0] seed_x = '0;
  logic [23:0] key_data;
  logic [31:0] word_count;
  int n_vec = 0, n_bad = 0, acc = 0, acc_base = 0;
  logic [23:0] q[$];
  logic [23:0] m_exp, w;
  logic [15:0] m_l[3];
  logic [15:0] m_x;
  int n, cyc;

  clfsr_keystream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .seed_lfsr  (seed_lfsr),
    .seed_x     (seed_x),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_data   (key_data),
    .word_count (word_count),
    .x_reinit   (x_reinit)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mmap(input logic [15:0] xi);
    longint p, t, d;
    p = longint'($signed(xi)) * longint'($signed(xi));
    t = p / 16384;
    if (t > 65535) t = 65535;
    d = 32767 - t;
    if (d < -32768) d = -32768;
    if (d > 32767) d = 32767;
    return d[15:0];
  endfunction

  task automatic m_reset();
    m_l[0] = 16'd1; m_l[1] = 16'd2; m_l[2] = 16'd3; m_x = 16'h7EF0;
  endtask

  task automatic gen_word(output logic [23:0] wo);
    logic [15:0] nx;
    wo = '0;
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 3; c++) begin
        wo[c*8 +: 8] = {wo[c*8 +: 7], m_l[c][15] ^ m_x[15]};
        m_l[c] = {m_l[c][14:0], ^(m_l[c] & 16'hB400)};
      end
      nx = mmap(m_x);
      m_x = (nx == m_x) ? 16'h7EF0 : nx;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!key_valid && cnt < 40);
    if (!key_valid) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_valid: got timeout want key_valid");
    end
  endtask

  // monitor: every accepted word is checked against the head of the expectation queue
  always @(negedge clk)
    if (rst_n && key_valid && key_ready) begin
      n_vec++;
      acc++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL word: got %h want none", key_data);
      end else begin
        m_exp = q.pop_front();
        if (key_data !== m_exp) begin
          n_bad++;
          $display("FAIL word %0d: got %h want %h", acc, key_data, m_exp);
        end
      end
    end

  initial begin
    tick();
    chk("rst_valid", key_valid, 0);
    chk("rst_data", key_data, 0);
    chk("rst_count", word_count, 0);
    chk("rst_reinit", x_reinit, 0);
    chk("rst_seed_ready", seed_ready, 1);
    rst_n = 1'b1;
    // first word from reset defaults: chaotic signs 0,1,1,1,0,0,0,0 and LFSR MSBs all zero
    m_reset();
    gen_word(w);
    q.push_back(24'h707070);
    enable = 1'b1;
    key_ready = 1'b1;
    wait_valid(n);
    chk("lat_first", n, 9);
    enable = 1'b0;
    tick();
    tick();
    chk("count_1", word_count, 1);
    chk("idle_seed_ready", seed_ready, 1);
    chk("idle_valid", key_valid, 0);
    // backpressure: word and state frozen while key_ready is low
    gen_word(w);
    q.push_back(w);
    key_ready = 1'b0;
    enable = 1'b1;
    wait_valid(n);
    chk("lat_bp", n, 9);
    for (int i = 0; i < 20; i++) begin
      chk("hold_valid", key_valid, 1);
      chk("hold_data", key_data, w);
      tick();
    end
    gen_word(w);
    q.push_back(w);
    key_ready = 1'b1;
    wait_valid(n);
    chk("lat_release", n, 9);
    chk("count_2", word_count, 2);
    enable = 1'b0;
    tick();
    chk("count_3", word_count, 3);
    // seeding with a zero channel seed and the degenerate x = -1 point
    seed_lfsr = {16'h1234, 16'h0000, 16'hACE1};
    seed_x = 16'h8000;
    seed_valid = 1'b1;
    chk("seed_ready_idle", seed_ready, 1);
    tick();
    seed_valid = 1'b0;
    m_l[0] = 16'hACE1; m_l[1] = 16'h0002; m_l[2] = 16'h1234; m_x = 16'h8000;
    gen_word(w);
    q.push_back(w);
    enable = 1'b1;
    tick();
    chk("reinit_pre", x_reinit, 0);
    tick();
    chk("reinit_pulse", x_reinit, 1);
    tick();
    chk("reinit_end", x_reinit, 0);
    // seed offer during RUN is ignored; disabling mid-word still completes the word
    seed_lfsr = '1;
    seed_x = 16'h0000;
    seed_valid = 1'b1;
    enable = 1'b0;
    chk("seed_ready_run_a", seed_ready, 0);
    tick();
    chk("seed_ready_run_b", seed_ready, 0);
    tick();
    seed_valid = 1'b0;
    wait_valid(n);
    chk("lat_disable", n, 4);
    tick();
    chk("back_idle", seed_ready, 1);
    chk("back_idle_valid", key_valid, 0);
    tick();
    chk("stay_idle", seed_ready, 1);
    chk("count_4", word_count, 4);
    // reset in the middle of a word discards it
    enable = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", key_valid, 0);
    chk("arst_data", key_data, 0);
    chk("arst_count", word_count, 0);
    chk("arst_reinit", x_reinit, 0);
    chk("arst_seed_ready", seed_ready, 1);
    acc_base = acc;
    m_reset();
    gen_word(w);
    q.push_back(24'h707070);
    tick();
    rst_n = 1'b1;
    wait_valid(n);
    chk("lat_after_rst", n, 9);
    // long run with random backpressure against the reference model
    for (int i = 0; i < 1000; i++) begin
      gen_word(w);
      q.push_back(w);
    end
    cyc = 0;
    while (q.size() > 1 && cyc < 40000) begin
      key_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    enable = 1'b0;
    key_ready = 1'b1;
    cyc = 0;
    while ((q.size() != 0 || !seed_ready || key_valid) && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("drain", q.size(), 0);
    chk("long_count", word_count, acc - acc_base);
    chk("long_count_abs", word_count, 1001);
    chk("long_idle", seed_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
